clk_step_ctrl: RTL
==================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 The block SHALL have parameter DebVal, default 500000, meaning stable Clk cycles required to accept a button level (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter CntW, default 20, meaning debounce counter width; DebVal-1 SHALL fit in CntW bits.
REQ-003 The block SHALL have port Clk, input, 1, 50 MHz system clock; the block SHALL use one clock only.
REQ-004 The block SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port SlowClk, input, 1, divided clock level from the clock divider, treated as asynchronous data.
REQ-006 The block SHALL have port BtnStep, input, 1, raw bouncing pushbutton, active-high.
REQ-007 The block SHALL have port ModeRun, input, 1, slide switch: 1 = free-run on SlowClk, 0 = single-step on button.
REQ-008 The block SHALL have port Halt, input, 1, stop request from the processor core, synchronous to Clk.
REQ-009 The block SHALL have port CpuEn, output, 1, registered one-Clk-cycle advance enable to the core.
REQ-010 The block SHALL have port StepCnt, output, 16, count of CpuEn pulses issued.
REQ-011 The block SHALL have port State, output, 2, current FSM state for debug display.

Function
REQ-012 SlowClk, BtnStep and ModeRun SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 SlowClk rise event SHALL be synchronized level 1 with the previous registered level 0; it lasts one Clk cycle per SlowClk period.
REQ-014 Debounce: the counter SHALL clear whenever synced BtnStep equals the debounced level, and otherwise increment; when it reaches DebVal-1, the debounced level SHALL take the synced value and the counter SHALL clear.
REQ-015 Press event SHALL be a debounced 0->1 transition, one Clk cycle wide; a release SHALL generate no event.
REQ-016 FSM states SHALL be IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-017 IDLE transitions: Halt -> HALTED; else ModeRun -> RUN; else press event -> STEP; otherwise stay.
REQ-018 RUN behaviour: Halt -> HALTED; else !ModeRun -> IDLE; else stay, and each SlowClk rise event SHALL set CpuEn high for the next cycle.
REQ-019 STEP behaviour: CpuEn SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE unconditionally; Halt in that cycle SHALL suppress CpuEn and go to HALTED.
REQ-020 HALTED behaviour: CpuEn SHALL stay 0; a press event with Halt=0 SHALL go to IDLE; ModeRun SHALL be ignored.
REQ-021 Halt SHALL have priority over every other event in every state, including a same-cycle SlowClk rise or press event.
REQ-022 In RUN, press events SHALL be ignored; in STEP/IDLE/HALTED, SlowClk rise events SHALL be ignored.
REQ-023 Latency: CpuEn SHALL go high no more than 4 Clk edges after the SlowClk rise, accounting for synchronizer sampling uncertainty.
REQ-024 CpuEn SHALL never be high on two consecutive cycles.
REQ-025 StepCnt SHALL increment by 1 in the cycle after each CpuEn pulse; it SHALL wrap from 0xFFFF to 0x0000.
REQ-026 A ModeRun change during STEP SHALL take effect only after the return to IDLE.

Reset
REQ-027 Rst high SHALL asynchronously force State=IDLE, CpuEn=0, StepCnt=0, all synchronizer flops, the debounced level and the debounce counter to 0.
REQ-028 Reset mid-operation SHALL drop CpuEn in the same instant, with no pulse completed; a press held through reset release SHALL register one press event after DebVal cycles.

Verification
REQ-029 Run mode: DebVal=4, ModeRun=1, SlowClk toggled every 10 Clk for 5 periods -> 5 one-cycle CpuEn pulses, each at most 4 Clk after its rise, StepCnt=5.
REQ-030 Bounce: ModeRun=0, BtnStep toggled 1/0 every 2 Clk for 20 Clk, then held 1 -> exactly one CpuEn, DebVal to DebVal+3 Clk after the final rise, State passes 00->10->00.
REQ-031 Halt priority: in RUN, Halt asserted in the same cycle as a SlowClk rise event -> no CpuEn, State=11; a later press with Halt=0 -> State=00.
REQ-032 Wrap: StepCnt preloaded to 0xFFFF by forcing 65535 pulses, one more pulse -> StepCnt=0x0000.
REQ-033 Async reset: Rst pulsed between Clk edges while CpuEn=1 -> CpuEn=0 and StepCnt=0 immediately, State=00.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl -- run / single-step clock-enable controller for a small CPU.
//
// Produces a one-Clk-cycle advance enable (CpuEn) for the core. There are
// three sources of enables:
//   - free-run: one enable per rising edge of the divided SlowClk level
//   - single-step: one enable per debounced press of a pushbutton
//   - halt: the core can request a stop at any time
//
// Ports
//   Clk      in   system clock (the only clock in this block)
//   Rst      in   asynchronous, active-high reset
//   SlowClk  in   divided clock level, sampled as asynchronous data
//   BtnStep  in   raw bouncing pushbutton, active-high
//   ModeRun  in   slide switch: 1 = free-run on SlowClk, 0 = single-step
//   Halt     in   stop request from the core, synchronous to Clk
//   CpuEn    out  registered one-cycle advance enable
//   StepCnt  out  number of CpuEn pulses issued (wraps at 16 bits)
//   State    out  FSM state for debug: IDLE=00 RUN=01 STEP=10 HALTED=11
module clk_step_ctrl #(
    parameter int DebVal = 500000,
    parameter int CntW   = 20
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        SlowClk,
    input  logic        BtnStep,
    input  logic        ModeRun,
    input  logic        Halt,
    output logic        CpuEn,
    output logic [15:0] StepCnt,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam logic [CntW-1:0] DEB_LAST = CntW'(DebVal - 1);

    state_t          state, state_nxt;
    logic            cpu_en, cpu_en_nxt;
    logic [15:0]     step_cnt;

    // Two-flop synchronizers; bit [1] is the synchronized level.
    logic [1:0]      slow_sync, btn_sync, mode_sync;
    logic            slow_prev;
    logic            slow_rise, btn_s, mode_s;

    logic            deb_lvl;
    logic [CntW-1:0] deb_cnt;
    logic            press;

    assign slow_rise = slow_sync[1] & ~slow_prev;
    assign btn_s     = btn_sync[1];
    assign mode_s    = mode_sync[1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            slow_sync <= '0;
            btn_sync  <= '0;
            mode_sync <= '0;
            slow_prev <= 1'b0;
        end else begin
            slow_sync <= {slow_sync[0], SlowClk};
            btn_sync  <= {btn_sync[0], BtnStep};
            mode_sync <= {mode_sync[0], ModeRun};
            slow_prev <= slow_sync[1];
        end
    end

    // Debounce: count consecutive cycles where the synced button differs from
    // the accepted level; any agreeing cycle restarts the count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == deb_lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_lvl <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CntW'(1);
        end
    end

    // Press is flagged in the very cycle the accepted level flips 0->1, which
    // saves a register stage of latency versus edge-detecting deb_lvl.
    assign press = btn_s & ~deb_lvl & (deb_cnt == DEB_LAST);

    // Halt outranks everything. STEP always leaves after one cycle, so a
    // ModeRun change seen during STEP is only acted on back in IDLE.
    always_comb begin
        state_nxt  = state;
        cpu_en_nxt = 1'b0;
        if (Halt) begin
            state_nxt = HALTED;
        end else begin
            case (state)
                IDLE: begin
                    if (mode_s)     state_nxt = RUN;
                    else if (press) state_nxt = STEP;
                end
                RUN: begin
                    if (!mode_s) state_nxt = IDLE;
                    else         cpu_en_nxt = slow_rise;
                end
                STEP: begin
                    cpu_en_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
                HALTED: begin
                    if (press) state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            cpu_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cpu_en <= cpu_en_nxt;
        end
    end

    // Written every cycle (adding zero when idle) so the count never relies
    // on holding a stale value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) step_cnt <= '0;
        else     step_cnt <= step_cnt + 16'(cpu_en);
    end

    assign CpuEn   = cpu_en;
    assign StepCnt = step_cnt;
    assign State   = state;

endmodule
